puf_framer: RTL and testbench

- Stage directly downstream of the linear-interpolating PUF resampler.
- Buffers the resampler's interpolated IQ stream in a small FIFO and regroups it into fixed-length packets of `spp` samples, asserting `out_tlast` on the last sample of each packet.
- Honours upstream end-of-burst: a partial packet closes early, or is zero-padded to full length when the optional feature is enabled.
- Feeds the radio/transport packetizer.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/puf_fifo.sv | 80 ++++++++
 rtl/puf_framer.sv | 154 +++++++++++++++
 tb/tb_puf_framer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
//   Shared definitions for the PUF framer slice.
//   - PUF_DATA_WIDTH / PUF_SAMPLE_W : default I/Q component and sample widths
//   - PUF_DEFAULT_SPP               : samples-per-packet used until the first
//                                     value is latched from the spp port
//   - state_t                       : framer FSM encoding (S_STREAM, S_PAD)
// -----------------------------------------------------------------------------
package puf_pkg;

  localparam int PUF_DATA_WIDTH  = 16;
  localparam int PUF_SAMPLE_W    = 2 * PUF_DATA_WIDTH;
  localparam int PUF_DEFAULT_SPP = 256;

  typedef enum logic [0:0] {
    S_STREAM = 1'b0,
    S_PAD    = 1'b1
  } state_t;

endpackage

// File: rtl/puf_fifo.sv
// -----------------------------------------------------------------------------
// puf_fifo
//   First-word-fall-through FIFO, 2**AW entries of WIDTH bits.
//
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     wr_data/wr_valid      write side; a write happens on wr_valid & wr_ready
//     wr_ready              registered "not full" (0 while in reset)
//     rd_data/rd_valid      head entry and "not empty"; rd_data is 0 when empty
//     rd_en                 pop the head (ignored when empty)
//     level                 exact occupancy, 0 .. 2**AW
//
//   The storage is read asynchronously so that an entry written on one edge is
//   already presented at the head during the following cycle (one-cycle
//   fall-through). With a small depth this maps to distributed RAM.
// -----------------------------------------------------------------------------
module puf_fifo #(
  parameter int WIDTH = 33,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_en,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty are distinct
  // and the level falls out of a plain subtraction.
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] level_next;
  logic        wr_ready_reg;
  logic        wr_fire, rd_fire;

  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign rd_valid = (level != '0);
  assign wr_ready = wr_ready_reg;

  assign wr_fire = wr_valid & wr_ready_reg;
  assign rd_fire = rd_en & rd_valid;

  assign wr_ptr_next = wr_fire ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
  assign rd_ptr_next = rd_fire ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
  assign level_next  = wr_ptr_next - rd_ptr_next;

  // Head is masked to zero when empty so the output bus is quiet after reset.
  assign rd_data = rd_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // wr_ready is registered from the next-cycle level: a read while full frees
  // a slot, but the write side only sees it one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wr_ready_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ready_reg <= (level_next != FULL_LEVEL);
    end
  end

endmodule

// File: rtl/puf_framer.sv
// -----------------------------------------------------------------------------
// puf_framer
//   Buffers the interpolated IQ stream from the PUF resampler and regroups it
//   into packets of spp samples, marking the last one with out_tlast. An
//   upstream end-of-burst (in_tlast) closes a partial packet early, or, when
//   built with PUF_FRAMER_PAD_EN defined, pads it with zero samples to full
//   length.
//
//   Ports:
//     clk, reset_n                       clock, asynchronous active-low reset
//     in_tdata/in_tvalid/in_tlast        sample {I,Q} and end-of-burst in
//     in_tready                          FIFO not full (registered)
//     out_tdata/out_tvalid/out_tlast     packetised stream out
//     out_tready                         downstream ready
//     spp                                samples per packet (0 behaves as 1)
//     pkt_count                          packets completed, wraps at 16 bits
//     fifo_level                         FIFO occupancy
//
//   Build option: define PUF_FRAMER_PAD_EN to enable zero padding of short
//   packets (adds the S_PAD state). Default build closes short packets early.
// -----------------------------------------------------------------------------
module puf_framer
  import puf_pkg::*;
#(
  parameter int DATA_WIDTH = PUF_SAMPLE_W / 2,
  parameter int FIFO_AW    = 5,
  parameter int SPP_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  input  logic [SPP_W-1:0]        spp,
  output logic [15:0]             pkt_count,
  output logic [FIFO_AW:0]        fifo_level
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [SPP_W-1:0] SPP_ONE = {{(SPP_W-1){1'b0}}, 1'b1};

  // FIFO entry: {eob, sample}
  logic [SW:0] fifo_wdata;
  logic [SW:0] head;
  logic        head_valid;
  logic        pop;

  state_t            state_reg;
  logic [SPP_W-1:0]  beat_reg;
  logic [SPP_W-1:0]  spp_q_reg;
  logic [15:0]       pkt_count_reg;

  logic [SPP_W-1:0]  spp_clamped;
  logic [SPP_W-1:0]  last_beat;
  logic              at_last;
  logic              head_eob;
  logic              fire;
  logic              tvalid_c;
  logic              tlast_c;
  logic [SW-1:0]     tdata_c;
  logic              spp_load;

  assign fifo_wdata = {in_tlast, in_tdata};

  puf_fifo #(
    .WIDTH (SW + 1),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (fifo_wdata),
    .wr_valid (in_tvalid),
    .wr_ready (in_tready),
    .rd_data  (head),
    .rd_valid (head_valid),
    .rd_en    (pop),
    .level    (fifo_level)
  );

  assign spp_clamped = (spp == '0) ? SPP_ONE : spp;
  assign last_beat   = spp_q_reg - SPP_ONE;
  assign at_last     = (beat_reg == last_beat);
  assign head_eob    = head[SW];

  // Output stage. Everything here is a function of registered state (FIFO
  // pointers/head, beat, spp_q, FSM state), so it holds steady under
  // backpressure without extra skid registers.
  always_comb begin
    tvalid_c = head_valid;
    tdata_c  = head[SW-1:0];
    tlast_c  = at_last | head_eob;
`ifdef PUF_FRAMER_PAD_EN
    if (state_reg == S_PAD) begin
      tvalid_c = 1'b1;
      tdata_c  = '0;
      tlast_c  = at_last;
    end else begin
      // An early eob is not a packet end here; padding finishes the packet.
      tlast_c  = at_last;
    end
`endif
  end

  assign fire = tvalid_c & out_tready;
  assign pop  = fire & (state_reg == S_STREAM);

  // spp is sampled while idle between packets, and also at the closing
  // handshake so back-to-back packets pick up a new value without a gap.
  assign spp_load = (fire & tlast_c) |
                    ((beat_reg == '0) & (state_reg == S_STREAM) & ~fire);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_STREAM;
      beat_reg      <= '0;
      spp_q_reg     <= SPP_W'(PUF_DEFAULT_SPP);
      pkt_count_reg <= '0;
    end else begin
      if (spp_load) begin
        spp_q_reg <= spp_clamped;
      end

      if (fire) begin
        if (tlast_c) begin
          beat_reg      <= '0;
          pkt_count_reg <= pkt_count_reg + 16'd1;
        end else begin
          beat_reg      <= beat_reg + SPP_ONE;
        end
      end

`ifdef PUF_FRAMER_PAD_EN
      case (state_reg)
        S_STREAM: if (fire && head_eob && !at_last) state_reg <= S_PAD;
        S_PAD:    if (fire && at_last)              state_reg <= S_STREAM;
        default:                                    state_reg <= S_STREAM;
      endcase
`else
      state_reg <= S_STREAM;
`endif
    end
  end

  assign out_tvalid = tvalid_c;
  assign out_tdata  = tdata_c;
  assign out_tlast  = tlast_c;
  assign pkt_count  = pkt_count_reg;

endmodule

// File: tb/tb_puf_framer.sv
// -----------------------------------------------------------------------------
// tb_puf_framer
//   Scoreboard bench for puf_framer. Accepted input samples are fed to a
//   packet-level reference model that appends the expected output beats to a
//   queue; an independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_puf_framer;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int SPW = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2*DW-1:0]   in_tdata;
  logic              in_tvalid;
  logic              in_tlast;
  logic              in_tready;
  logic [2*DW-1:0]   out_tdata;
  logic              out_tvalid;
  logic              out_tlast;
  logic              out_tready;
  logic [SPW-1:0]    spp;
  logic [15:0]       pkt_count;
  logic [AW:0]       fifo_level;

  puf_framer #(.DATA_WIDTH(DW), .FIFO_AW(AW), .SPP_W(SPW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .spp        (spp),
    .pkt_count  (pkt_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected output beats {tlast, data}
  logic [2*DW:0] exp_q[$];
  int m_beat = 0;
  int m_spp  = 1;
  int m_pkts = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: packets of spp (latched at packet start) samples; an
  // eob ends the packet early, or is followed by zero padding when enabled.
  task automatic model_push(input logic [2*DW-1:0] d, input bit eob);
    if (m_beat == 0) m_spp = (spp == 0) ? 1 : int'(spp);
    if (m_beat == m_spp - 1 || eob) begin
`ifdef PUF_FRAMER_PAD_EN
      if (m_beat != m_spp - 1) begin
        exp_q.push_back({1'b0, d});
        m_beat++;
        while (m_beat < m_spp - 1) begin
          exp_q.push_back({1'b0, {(2*DW){1'b0}}});
          m_beat++;
        end
        exp_q.push_back({1'b1, {(2*DW){1'b0}}});
      end else begin
        exp_q.push_back({1'b1, d});
      end
`else
      exp_q.push_back({1'b1, d});
`endif
      m_beat = 0;
      m_pkts++;
    end else begin
      exp_q.push_back({1'b0, d});
      m_beat++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2*DW-1:0] d, input bit l);
    int t = 0;
    bit acc = 0;
    in_tdata  = d;
    in_tvalid = 1'b1;
    in_tlast  = l;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk); #1;
      t++;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    else model_push(d, l);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || fifo_level != 0) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Downstream ready generator
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) out_tready = ($urandom_range(0, 9) < 7);
      else               out_tready = (rdy_mode == 1);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {31'd0, out_tlast, out_tdata}, 64'hDEAD);
      end else begin
        logic [2*DW:0] e;
        e = exp_q.pop_front();
        chk("out_sample", {31'd0, out_tlast, out_tdata}, {31'd0, e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n   = 1'b0;
    in_tdata  = '0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    spp       = 16'd4;
    rdy_mode  = 1;

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_in_tready",  64'(in_tready),  64'd0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tlast",  64'(out_tlast),  64'd0);
    chk("rst_out_tdata",  64'(out_tdata),  64'd0);
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    chk("rst_pkt_count",  64'(pkt_count),  64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("in_tready_after_rst", 64'(in_tready), 64'd1);
    idle(2);

    // Test 1: spp=4, samples 1..12, first-output latency
    in_tdata  = 32'd1;
    in_tvalid = 1'b1;
    @(negedge clk);
    chk("lat_not_same_cycle", 64'(out_tvalid), 64'd0);
    model_push(32'd1, 1'b0);
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    chk("lat_next_cycle_valid", 64'(out_tvalid), 64'd1);
    chk("lat_next_cycle_data",  64'(out_tdata),  64'd1);
    for (int i = 2; i <= 12; i++) send(32'(i), 1'b0);
    wait_drain();
    chk("pkt_count_t1", 64'(pkt_count), 64'd3);

    // Test 2: backpressure fills the FIFO
    rdy_mode = 0;
    idle(2);
    cnt = 0;
    in_tvalid = 1'b1;
    in_tdata  = 32'h1000;
    for (int c = 0; c < 40; c++) begin
      bit acc;
      @(negedge clk);
      acc = in_tready;
      @(posedge clk); #1;
      if (acc) begin
        model_push(in_tdata, 1'b0);
        cnt++;
        in_tdata = 32'h1000 + 32'(cnt);
      end
    end
    in_tvalid = 1'b0;
    chk("bp_accepted",   64'(cnt),        64'd32);
    chk("bp_fifo_level", 64'(fifo_level), 64'd32);
    chk("bp_in_tready",  64'(in_tready),  64'd0);
    rdy_mode = 1;
    wait_drain();
    chk("pkt_count_t2", 64'(pkt_count), 64'(m_pkts));

    // Test 3: spp=5, early eob on the 3rd sample
    spp = 16'd5;
    idle(2);
    send(32'hA001, 1'b0);
    send(32'hA002, 1'b0);
    send(32'hA003, 1'b1);
    wait_drain();
    chk("pkt_count_t3", 64'(pkt_count), 64'(m_pkts));

    // Test 4: spp 4 -> 2 after the 2nd beat of a packet
    spp = 16'd4;
    idle(2);
    send(32'hB001, 1'b0);
    send(32'hB002, 1'b0);
    wait_drain();
    spp = 16'd2;
    for (int i = 3; i <= 10; i++) send(32'hB000 + 32'(i), 1'b0);
    wait_drain();
    chk("pkt_count_t4", 64'(pkt_count), 64'(m_pkts));

    // Test 5: spp=0 behaves as 1
    spp = 16'd0;
    idle(2);
    for (int i = 0; i < 5; i++) send($urandom, 1'b0);
    wait_drain();
    chk("pkt_count_t5", 64'(pkt_count), 64'(m_pkts));

    // Test 6: randomized rounds, each closed with an eob
    for (int r = 0; r < 6; r++) begin
      int n;
      spp = 16'($urandom_range(0, 6));
      idle(2);
      rdy_mode = 2;
      n = $urandom_range(8, 24);
      for (int i = 0; i < n; i++) begin
        bit eob;
        eob = (i == n - 1) || ($urandom_range(0, 5) == 0);
        send($urandom, eob);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      wait_drain();
      rdy_mode = 1;
      idle(2);
      chk("pkt_count_rand", 64'(pkt_count), 64'(m_pkts & 16'hFFFF));
    end

    // Test 7: asynchronous reset mid-packet with 10 entries buffered
    spp = 16'd4;
    rdy_mode = 0;
    idle(3);
    for (int i = 0; i < 10; i++) send(32'hC000 + 32'(i), 1'b0);
    chk("pre_rst_level", 64'(fifo_level), 64'd10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("arst_fifo_level", 64'(fifo_level), 64'd0);
    chk("arst_pkt_count",  64'(pkt_count),  64'd0);
    exp_q.delete();
    m_beat = 0;
    m_pkts = 0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 4; i++) send(32'hD000 + 32'(i), 1'b0);
    wait_drain();
    chk("pkt_count_after_rst", 64'(pkt_count), 64'd1);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
